// File: rtl/unidade_funcional_pipe.sv
// ---------------------------------------------------------------------------
// unidade_funcional_pipe
// Multi-cycle functional unit for a Tomasulo-style core. It accepts one
// instruction from a reservation station and computes the result over a
// latency that depends on the opcode class. The result is then offered on
// the common data bus until the CDB arbiter grants it.
//
// Optional feature macro: UF_DIV_EN
//   defined   -> opcode 0101 is an unsigned divide with latency DIV_LAT
//   undefined -> no divider is built; opcode 0101 is an illegal opcode
//
// Parameters
//   WIDTH   operand/result width
//   TAG_W   reservation-station tag width
//   ADD_LAT latency of add/sub/ld/sd and of illegal opcodes (>=1)
//   MUL_LAT latency of mul (>=1)
//   DIV_LAT latency of div (>=1), only meaningful with UF_DIV_EN
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   issue_valid  an instruction is offered
//   issue_ready  unit is idle and will accept an instruction
//   issue_op     4-bit opcode
//   issue_tag    reservation-station tag
//   reg1, reg2   operands A and B
//   cdb_valid    a result is offered on the CDB
//   cdb_grant    the CDB arbiter takes the offered result
//   cdb_tag      tag of the offered result
//   cdb_data     result value
//   cdb_err      illegal opcode or divide-by-zero
//   busy         unit is executing or holding a result
//   current_op   opcode held by the unit (4'b1111 after reset)
// ---------------------------------------------------------------------------
module unidade_funcional_pipe #(
   parameter int WIDTH   = 16,
   parameter int TAG_W   = 3,
   parameter int ADD_LAT = 1,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [3:0]       issue_op,
   input  logic [TAG_W-1:0] issue_tag,
   input  logic [WIDTH-1:0] reg1,
   input  logic [WIDTH-1:0] reg2,
   output logic             cdb_valid,
   input  logic             cdb_grant,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [WIDTH-1:0] cdb_data,
   output logic             cdb_err,
   output logic             busy,
   output logic [3:0]       current_op
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_SD  = 4'b0011;
   localparam logic [3:0] OP_MUL = 4'b0100;
`ifdef UF_DIV_EN
   localparam logic [3:0] OP_DIV = 4'b0101;
`endif

   // The counter only ever holds LAT-1, so it is sized for the longest class.
   localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
   localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         op_q;
   logic [TAG_W-1:0]   tag_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   res_val;
   logic               res_err;

   // Latency counter preload for the opcode being accepted. Anything that is
   // not a multiply (or an enabled divide) runs in the short add class,
   // which includes illegal opcodes.
   function automatic logic [CNT_W-1:0] lat_load(input logic [3:0] op);
      logic [CNT_W-1:0] v;
      case (op)
         OP_MUL:  v = CNT_W'(MUL_LAT - 1);
`ifdef UF_DIV_EN
         OP_DIV:  v = CNT_W'(DIV_LAT - 1);
`endif
         default: v = CNT_W'(ADD_LAT - 1);
      endcase
      return v;
   endfunction

   // Result datapath works only on the operands captured at acceptance, so
   // whatever the reservation station drives afterwards cannot leak in.
   always_comb begin
      res_val = '0;
      res_err = 1'b0;
      case (op_q)
         OP_ADD:        res_val = b_q + a_q;
         OP_SUB:        res_val = a_q - b_q;
         OP_LD, OP_SD:  res_val = a_q + b_q;
         OP_MUL:        res_val = a_q * b_q;
`ifdef UF_DIV_EN
         OP_DIV: begin
            if (b_q == '0) begin
               res_val = '1;
               res_err = 1'b1;
            end else begin
               res_val = a_q / b_q;
            end
         end
`endif
         default: begin
            res_val = '0;
            res_err = 1'b1;
         end
      endcase
   end

   // Next-state logic and the state-decoded handshake outputs. A grant seen
   // outside DONE has no effect because only the DONE arm looks at it.
   always_comb begin
      state_next  = state;
      issue_ready = 1'b0;
      cdb_valid   = 1'b0;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            issue_ready = 1'b1;
            busy        = 1'b0;
            if (issue_valid) state_next = EXEC;
         end
         EXEC: begin
            if (cnt == '0) state_next = DONE;
         end
         DONE: begin
            cdb_valid = 1'b1;
            if (cdb_grant) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register plus operand capture, latency countdown and result
   // registration. The result is written only on the EXEC->DONE edge so the
   // CDB outputs stay frozen for the whole time the result waits for grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op_q     <= 4'b1111;
         tag_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cdb_data <= '0;
         cdb_tag  <= '0;
         cdb_err  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (issue_valid) begin
                  op_q  <= issue_op;
                  tag_q <= issue_tag;
                  a_q   <= reg1;
                  b_q   <= reg2;
                  cnt   <= lat_load(issue_op);
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  cdb_data <= res_val;
                  cdb_err  <= res_err;
                  cdb_tag  <= tag_q;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign current_op = op_q;

endmodule

// File: tb/tb_unidade_funcional_pipe.sv
// ---------------------------------------------------------------------------
// tb_unidade_funcional_pipe
// Directed self-checking bench for unidade_funcional_pipe with default
// parameters (WIDTH=16, TAG_W=3, ADD_LAT=1, MUL_LAT=3, DIV_LAT=8). Inputs
// change on the falling edge; outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_unidade_funcional_pipe;

   logic        clock;
   logic        reset;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_op;
   logic [2:0]  issue_tag;
   logic [15:0] reg1;
   logic [15:0] reg2;
   logic        cdb_valid;
   logic        cdb_grant;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic        cdb_err;
   logic        busy;
   logic [3:0]  current_op;

   int totalChecks = 0;
   int badChecks   = 0;

   unidade_funcional_pipe dut (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_tag   (issue_tag),
      .reg1        (reg1),
      .reg2        (reg2),
      .cdb_valid   (cdb_valid),
      .cdb_grant   (cdb_grant),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .cdb_err     (cdb_err),
      .busy        (busy),
      .current_op  (current_op)
   );

   // 10-unit clock period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, observed, expected);
      end
   endtask

   // Offers one instruction, drops issue_valid right after the acceptance
   // edge and scrambles the operands, then counts edges until cdb_valid
   task automatic applyStimulus(input logic [3:0] op, input logic [2:0] tg,
                                input logic [15:0] a, input logic [15:0] b,
                                output int lat);
      @(negedge clock);
      issue_valid = 1'b1;
      issue_op    = op;
      issue_tag   = tg;
      reg1        = a;
      reg2        = b;
      @(posedge clock);
      #1;
      issue_valid = 1'b0;
      reg1        = 16'hDEAD;
      reg2        = 16'hBEEF;
      issue_tag   = ~tg;
      lat = 0;
      while (!cdb_valid && lat < 40) begin
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   // Grants the pending result for one edge and checks the unit is idle again
   task automatic releaseResult(input string name);
      @(negedge clock);
      cdb_grant = 1'b1;
      @(posedge clock);
      #1;
      cdb_grant = 1'b0;
      checkOutput({name, "_valid_drop"}, 32'(cdb_valid), 32'd0);
      checkOutput({name, "_ready_back"}, 32'(issue_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int seen;
      int accepts;
      int results;
      logic [15:0] expQ[$];
      logic [15:0] a;
      logic [15:0] b;

      reset       = 1'b1;
      issue_valid = 1'b0;
      issue_op    = 4'b0000;
      issue_tag   = 3'd0;
      reg1        = 16'd0;
      reg2        = 16'd0;
      cdb_grant   = 1'b0;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst_valid", 32'(cdb_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ready", 32'(issue_ready), 32'd1);
      checkOutput("rst_curop", 32'(current_op), 32'hF);
      checkOutput("rst_data", 32'(cdb_data), 32'd0);
      checkOutput("rst_tag", 32'(cdb_tag), 32'd0);
      checkOutput("rst_err", 32'(cdb_err), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // add 5+7 tag 2 with grant held high the whole time
      cdb_grant = 1'b1;
      applyStimulus(4'b0000, 3'd2, 16'd5, 16'd7, lat);
      checkOutput("add_lat", 32'(lat), 32'd1);
      checkOutput("add_data", 32'(cdb_data), 32'd12);
      checkOutput("add_tag", 32'(cdb_tag), 32'd2);
      checkOutput("add_err", 32'(cdb_err), 32'd0);
      checkOutput("add_busy", 32'(busy), 32'd1);
      checkOutput("add_curop", 32'(current_op), 32'h0);
      @(posedge clock);
      #1;
      checkOutput("add_valid_drop", 32'(cdb_valid), 32'd0);
      checkOutput("add_ready_back", 32'(issue_ready), 32'd1);
      @(negedge clock);
      cdb_grant = 1'b0;

      // mul 0x0100*0x0100 wraps to zero
      applyStimulus(4'b0100, 3'd1, 16'h0100, 16'h0100, lat);
      checkOutput("mulw_lat", 32'(lat), 32'd3);
      checkOutput("mulw_data", 32'(cdb_data), 32'h0);
      checkOutput("mulw_tag", 32'(cdb_tag), 32'd1);
      checkOutput("mulw_curop", 32'(current_op), 32'h4);
      releaseResult("mulw");

      // mul 300*7 = 2100
      applyStimulus(4'b0100, 3'd6, 16'd300, 16'd7, lat);
      checkOutput("mul_lat", 32'(lat), 32'd3);
      checkOutput("mul_data", 32'(cdb_data), 32'd2100);
      checkOutput("mul_err", 32'(cdb_err), 32'd0);
      releaseResult("mul");

      // sub 3-5 wraps to 0xFFFE
      applyStimulus(4'b0001, 3'd3, 16'd3, 16'd5, lat);
      checkOutput("subw_lat", 32'(lat), 32'd1);
      checkOutput("subw_data", 32'(cdb_data), 32'hFFFE);
      releaseResult("subw");

      // ld 0x1000+0x0234 and sd 0xFFFF+2 (wraps to 1)
      applyStimulus(4'b0010, 3'd4, 16'h1000, 16'h0234, lat);
      checkOutput("ld_lat", 32'(lat), 32'd1);
      checkOutput("ld_data", 32'(cdb_data), 32'h1234);
      releaseResult("ld");
      applyStimulus(4'b0011, 3'd7, 16'hFFFF, 16'd2, lat);
      checkOutput("sd_data", 32'(cdb_data), 32'h0001);
      checkOutput("sd_tag", 32'(cdb_tag), 32'd7);
      releaseResult("sd");

      // opcode 0101 with divisor zero
      applyStimulus(4'b0101, 3'd2, 16'd20, 16'd0, lat);
`ifdef UF_DIV_EN
      checkOutput("div0_lat", 32'(lat), 32'd8);
      checkOutput("div0_data", 32'(cdb_data), 32'hFFFF);
`else
      checkOutput("div0_lat", 32'(lat), 32'd1);
      checkOutput("div0_data", 32'(cdb_data), 32'h0);
`endif
      checkOutput("div0_err", 32'(cdb_err), 32'd1);
      releaseResult("div0");
`ifdef UF_DIV_EN
      applyStimulus(4'b0101, 3'd3, 16'd100, 16'd7, lat);
      checkOutput("div_lat", 32'(lat), 32'd8);
      checkOutput("div_data", 32'(cdb_data), 32'd14);
      checkOutput("div_err", 32'(cdb_err), 32'd0);
      releaseResult("div");
`endif

      // undefined opcode 1010
      applyStimulus(4'b1010, 3'd5, 16'd11, 16'd22, lat);
      checkOutput("ill_lat", 32'(lat), 32'd1);
      checkOutput("ill_data", 32'(cdb_data), 32'h0);
      checkOutput("ill_err", 32'(cdb_err), 32'd1);
      releaseResult("ill");

      // legal result after an error clears the flag
      applyStimulus(4'b0000, 3'd0, 16'd1, 16'd1, lat);
      checkOutput("clr_err", 32'(cdb_err), 32'd0);
      checkOutput("clr_data", 32'(cdb_data), 32'd2);
      releaseResult("clr");

      // grant stall: sub 9-4 tag 5 held for 4 cycles
      applyStimulus(4'b0001, 3'd5, 16'd9, 16'd4, lat);
      checkOutput("stall_lat", 32'(lat), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         checkOutput($sformatf("stall_valid%0d", i), 32'(cdb_valid), 32'd1);
         checkOutput($sformatf("stall_data%0d", i), 32'(cdb_data), 32'd5);
         checkOutput($sformatf("stall_tag%0d", i), 32'(cdb_tag), 32'd5);
         checkOutput($sformatf("stall_ready%0d", i), 32'(issue_ready), 32'd0);
      end
      releaseResult("stall");

      // reset abort during the second EXEC cycle of a mul
      @(negedge clock);
      issue_valid = 1'b1;
      issue_op    = 4'b0100;
      issue_tag   = 3'd6;
      reg1        = 16'd3;
      reg2        = 16'd4;
      @(posedge clock);
      #1;
      issue_valid = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("abort_exec_busy", 32'(busy), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_curop", 32'(current_op), 32'hF);
      checkOutput("abort_ready", 32'(issue_ready), 32'd1);
      checkOutput("abort_data", 32'(cdb_data), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock);
         #1;
         if (cdb_valid) seen++;
      end
      checkOutput("abort_no_result", 32'(seen), 32'd0);

      // input isolation: issue_valid held high, operands change every cycle,
      // grant held high; one acceptance every 3 cycles
      accepts = 0;
      results = 0;
      cdb_grant = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         a = 16'(i * 3 + 1);
         b = 16'(i * 5 + 2);
         issue_valid = 1'b1;
         issue_op    = 4'b0000;
         issue_tag   = 3'(i);
         reg1        = a;
         reg2        = b;
         if (issue_ready) begin
            accepts++;
            expQ.push_back(a + b);
         end
         @(posedge clock);
         #1;
         if (cdb_valid) begin
            results++;
            if (expQ.size() > 0)
               checkOutput($sformatf("iso_data%0d", results), 32'(cdb_data), 32'(expQ.pop_front()));
            else
               checkOutput("iso_unexpected", 32'(cdb_valid), 32'd0);
         end
      end
      @(negedge clock);
      issue_valid = 1'b0;
      cdb_grant   = 1'b0;
      checkOutput("iso_accepts", 32'(accepts), 32'd4);
      checkOutput("iso_results", 32'(results), 32'd4);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   // Global watchdog in case a wait above never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
